game_ctl: RTL and testbench
===========================

# game_ctl

Turn-sequencing controller for the tic-tac-toe display pipeline. It takes decoded mouse clicks (cell index 0–8) and a start pulse, and maintains the 3×3 board. It alternates players X and O, detects a win or draw, and drives the per-square enables and `start_en` consumed by the square-drawing stages. Board outputs to the drawing chain change only at a frame boundary, so a square never lights mid-frame.

## Interface
Parameters:
- `CELLS`, 9: number of board cells; fixed at 9, not meant to be overridden.

Ports:
- `pclk` in 1: pixel clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; begins a new game.
- `click` in 1: one-cycle pulse; a cell was clicked.
- `click_cell` in 4: clicked cell index. Row-major, 0 = top-left (square1), 8 = bottom-right. Values 9–15 are invalid.
- `vsync_in` in 1: vertical sync from the timing chain; rising edge marks the frame boundary.
- `start_en` out 1: high whenever state ≠ IDLE.
- `square_x` out 9: displayed X ownership, bit i = cell i.
- `square_o` out 9: displayed O ownership, bit i = cell i.
- `player` out 1: side to move; 0 = X, 1 = O.
- `winner` out 2: 00 none, 01 X, 10 O, 11 draw.
- `game_over` out 1: high in state DONE.

## Operation
- States:
  - IDLE: after reset.
  - TURN: awaiting a move.
  - CHECK: evaluating the move just placed.
  - DONE: game finished.
- Internal board: `bx[8:0]`, `bo[8:0]`, move counter `moves[3:0]` (0..9).
- `start` pulse, any state:
  - Clear `bx`, `bo`, `moves`, `winner`; set `player` = 0.
  - Go to TURN.
  - `start` has priority over a same-cycle `click`.
- TURN, `click` = 1: move accepted only if `click_cell` ≤ 8 and `bx[c]` = `bo[c]` = 0.
  - Accepted: set the current player's bit, `moves` += 1, go to CHECK.
  - Rejected (invalid index or occupied cell): no change, stay in TURN.
- CHECK, one cycle: test the 8 lines against the current player's board only.
  - Lines: rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonals {0,4,8}, {2,4,6}.
  - Line complete: `winner` = 01 or 10, go to DONE.
  - Else if `moves` = 9: `winner` = 11, go to DONE.
  - Else: toggle `player`, go to TURN.
  - A win on move 9 reports the win, not a draw.
- `click` in IDLE, CHECK or DONE: ignored.
- DONE: hold the board, `winner` and `player` until `start`.
- Frame sync:
  - `vsync_prev` registers `vsync_in`.
  - On `vsync_in` & ~`vsync_prev`: `square_x` ← `bx`, `square_o` ← `bo`.
  - No update on any other cycle.
- Invariant: `bx` & `bo` = 0 at all times; `moves` never exceeds 9.

## Timing
- Reset (asynchronous, active-low) clears the following immediately, without waiting for a clock edge:
  - state = IDLE;
  - `start_en`, `player`, `game_over`, `vsync_prev` = 0;
  - `winner` = 00;
  - `square_x`, `square_o`, `bx`, `bo`, `moves` = 0.
- Reset asserted mid-game aborts the game with no residue. After release, the block waits in IDLE for `start`.
- Accepted click in cycle N:
  - board bit and `moves` updated at edge N+1;
  - CHECK during N+1;
  - `player`/`winner`/state valid after edge N+2.
  - A second click in cycle N+1 (during CHECK) is dropped.
- `start` in cycle N: TURN and `start_en` = 1 after edge N+1.
- `start` in cycle N, board clear:
  - internal board is clear after edge N+1;
  - displayed board clears at the next vsync rising edge.
- Display latency: `square_x`/`square_o` change 1 cycle after the cycle in which the vsync rising edge is seen. Worst case ≈ one frame after the internal update.
- Same-cycle internal update and vsync edge: the display latches the pre-update board; the new mark appears on the following frame.

## Test plan
- Reset, then `start`:
  - `start_en` = 1, `player` = 0, `winner` = 00.
  - After the next vsync edge, `square_x` = `square_o` = 0.
- X clicks 0, O clicks 3, X 1, O 4, X 2:
  - `winner` = 01 and `game_over` = 1, two cycles after the last click.
  - After the vsync edge, `square_x` = 0x007, `square_o` = 0x018.
- Moves X0, O4, X8, O2, X6, O3, X5, O7, X1 (no line):
  - after move 9, `winner` = 11;
  - `square_x` = 0x163, `square_o` = 0x09C.
- X clicks 4, then O clicks 4, then `click_cell` = 12:
  - both rejected;
  - `player` stays 1, `moves` = 1, `bo` = 0.
- Click with no vsync edge for 1000 cycles:
  - `square_x` unchanged throughout;
  - updates one cycle after the cycle in which the vsync rising edge is seen.
- `start` and `click` (cell 0) in the same cycle mid-game: board cleared, click ignored. Then assert `rst` mid-game: all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/game_ctl.sv
// Tic-tac-toe turn sequencer: owns the 3x3 board, alternates X/O, detects win/draw,
// and republishes the board to the drawing chain only on a vsync rising edge.
module game_ctl #(
   parameter int CELLS = 9
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             start,
   input  logic             click,
   input  logic [3:0]       click_cell,
   input  logic             vsync_in,
   output logic             start_en,
   output logic [CELLS-1:0] square_x,
   output logic [CELLS-1:0] square_o,
   output logic             player,
   output logic [1:0]       winner,
   output logic             game_over
);

   typedef enum logic [1:0] {IDLE, TURN, CHECK, DONE} state_t;

   localparam logic [CELLS-1:0] LINES [8] = '{
      9'h007, 9'h038, 9'h1C0,   // rows
      9'h049, 9'h092, 9'h124,   // columns
      9'h111, 9'h054            // diagonals
   };

   state_t           r_state;
   logic [CELLS-1:0] r_bx, r_bo;
   logic [3:0]       r_moves;
   logic             r_vsync_prev;

   logic [15:0]      w_occ;
   logic             w_cell_ok;
   logic [CELLS-1:0] w_onehot;
   logic [CELLS-1:0] w_pboard;
   logic             w_line;
   logic             w_vs_rise;

   // Indices 9..15 read as occupied, so one lookup rejects both bad index and taken cell.
   assign w_occ     = {7'h7F, r_bx | r_bo};
   assign w_cell_ok = ~w_occ[click_cell];
   assign w_onehot  = CELLS'(1) << click_cell;
   assign w_pboard  = player ? r_bo : r_bx;
   assign w_vs_rise = vsync_in & ~r_vsync_prev;

   always_comb begin
      w_line = 1'b0;
      for (int i = 0; i < 8; i++)
         if ((w_pboard & LINES[i]) == LINES[i]) w_line = 1'b1;
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_bx         <= '0;
         r_bo         <= '0;
         r_moves      <= '0;
         r_vsync_prev <= 1'b0;
         start_en     <= 1'b0;
         square_x     <= '0;
         square_o     <= '0;
         player       <= 1'b0;
         winner       <= 2'b00;
         game_over    <= 1'b0;
      end else begin
         r_vsync_prev <= vsync_in;
         if (w_vs_rise) begin
            square_x <= r_bx;
            square_o <= r_bo;
         end

         if (start) begin
            r_state   <= TURN;
            r_bx      <= '0;
            r_bo      <= '0;
            r_moves   <= '0;
            player    <= 1'b0;
            winner    <= 2'b00;
            start_en  <= 1'b1;
            game_over <= 1'b0;
         end else begin
            case (r_state)
               TURN: if (click && w_cell_ok) begin
                  if (player) r_bo <= r_bo | w_onehot;
                  else        r_bx <= r_bx | w_onehot;
                  r_moves <= 4'(r_moves + 4'd1);
                  r_state <= CHECK;
               end
               CHECK: begin
                  // A completed line wins even on the ninth move.
                  if (w_line) begin
                     winner    <= player ? 2'b10 : 2'b01;
                     r_state   <= DONE;
                     game_over <= 1'b1;
                  end else if (r_moves == 4'd9) begin
                     winner    <= 2'b11;
                     r_state   <= DONE;
                     game_over <= 1'b1;
                  end else begin
                     player  <= ~player;
                     r_state <= TURN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: reset, win, draw, rejected moves, frame-sync hold, start/click priority.
module tb_game_ctl;
   logic       pclk = 1'b0;
   logic       rst  = 1'b1;
   logic       start = 1'b0, click = 1'b0, vsync_in = 1'b0;
   logic [3:0] click_cell = 4'd0;
   logic       start_en, player, game_over;
   logic [8:0] square_x, square_o;
   logic [1:0] winner;

   int checks = 0;
   int errors = 0;

   game_ctl #(.CELLS(9)) dut (
      .pclk(pclk), .rst(rst), .start(start), .click(click), .click_cell(click_cell),
      .vsync_in(vsync_in), .start_en(start_en), .square_x(square_x), .square_o(square_o),
      .player(player), .winner(winner), .game_over(game_over)
   );

   always #5 pclk = ~pclk;

   task automatic do_start();
      @(negedge pclk); start = 1'b1;
      @(negedge pclk); start = 1'b0;
   endtask

   // Click pulse plus one extra cycle so CHECK has resolved before sampling.
   task automatic do_move(input logic [3:0] c);
      @(negedge pclk); click = 1'b1; click_cell = c;
      @(negedge pclk); click = 1'b0;
      @(negedge pclk);
   endtask

   task automatic do_vsync();
      @(negedge pclk); vsync_in = 1'b1;
      @(negedge pclk); vsync_in = 1'b0;
      @(negedge pclk);
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      checks++; if ({start_en, player, game_over} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b want 000", {start_en, player, game_over}); end
      checks++; if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %b want 00", winner); end
      checks++; if ({square_x, square_o} !== 18'h0) begin errors++; $display("FAIL reset_squares got %h/%h want 0/0", square_x, square_o); end
      @(negedge pclk); rst = 1'b1;
      do_move(4'd0);
      do_vsync();
      checks++; if (start_en !== 1'b0 || square_x !== 9'h0) begin errors++; $display("FAIL idle_click start_en %b sq_x %h want 0 000", start_en, square_x); end
   endtask

   task automatic test_x_win();
      do_start();
      checks++; if ({start_en, player, winner} !== 4'b1000) begin errors++; $display("FAIL start_state got %b want 1000", {start_en, player, winner}); end
      do_vsync();
      checks++; if ({square_x, square_o} !== 18'h0) begin errors++; $display("FAIL start_squares got %h/%h want 0/0", square_x, square_o); end
      @(negedge pclk); click = 1'b1; click_cell = 4'd0;
      @(negedge pclk); click = 1'b0;
      checks++; if (player !== 1'b0) begin errors++; $display("FAIL check_cycle_player got %b want 0", player); end
      @(negedge pclk);
      checks++; if (player !== 1'b1) begin errors++; $display("FAIL after_move_player got %b want 1", player); end
      do_move(4'd3); do_move(4'd1); do_move(4'd4); do_move(4'd2);
      checks++; if (winner !== 2'b01 || game_over !== 1'b1) begin errors++; $display("FAIL x_win got %b/%b want 01/1", winner, game_over); end
      do_vsync();
      checks++; if (square_x !== 9'h007 || square_o !== 9'h018) begin errors++; $display("FAIL x_win_squares got %h/%h want 007/018", square_x, square_o); end
      do_move(4'd8);
      do_vsync();
      checks++; if (square_x !== 9'h007 || square_o !== 9'h018 || winner !== 2'b01) begin errors++; $display("FAIL done_hold got %h/%h/%b want 007/018/01", square_x, square_o, winner); end
   endtask

   task automatic test_draw();
      logic [3:0] seq [9];
      seq = '{4'd0, 4'd4, 4'd8, 4'd2, 4'd6, 4'd3, 4'd5, 4'd7, 4'd1};
      do_start();
      for (int i = 0; i < 8; i++) do_move(seq[i]);
      checks++; if (winner !== 2'b00 || game_over !== 1'b0) begin errors++; $display("FAIL pre_draw got %b/%b want 00/0", winner, game_over); end
      do_move(seq[8]);
      checks++; if (winner !== 2'b11 || game_over !== 1'b1) begin errors++; $display("FAIL draw got %b/%b want 11/1", winner, game_over); end
      do_vsync();
      checks++; if (square_x !== 9'h163 || square_o !== 9'h09C) begin errors++; $display("FAIL draw_squares got %h/%h want 163/09c", square_x, square_o); end
   endtask

   task automatic test_reject();
      do_start();
      do_move(4'd4);
      do_move(4'd4);
      do_move(4'd12);
      checks++; if (player !== 1'b1 || winner !== 2'b00) begin errors++; $display("FAIL reject_player got %b/%b want 1/00", player, winner); end
      do_vsync();
      checks++; if (square_x !== 9'h010 || square_o !== 9'h000) begin errors++; $display("FAIL reject_squares got %h/%h want 010/000", square_x, square_o); end
      do_move(4'd0);
      do_vsync();
      checks++; if (player !== 1'b0 || square_o !== 9'h001) begin errors++; $display("FAIL reject_then_ok got %b/%h want 0/001", player, square_o); end
   endtask

   task automatic test_frame_sync();
      int bad = 0;
      do_start();
      do_vsync();
      // vsync rises in the same cycle as the click: display must take the old board.
      @(negedge pclk); click = 1'b1; click_cell = 4'd0; vsync_in = 1'b1;
      @(negedge pclk); click = 1'b0;
      checks++; if (square_x !== 9'h000) begin errors++; $display("FAIL same_cycle_vsync got %h want 000", square_x); end
      @(negedge pclk); vsync_in = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge pclk);
         if (square_x !== 9'h000) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL hold_no_vsync changed %0d cycles want 0", bad); end
      @(negedge pclk); vsync_in = 1'b1;
      #1;
      checks++; if (square_x !== 9'h000) begin errors++; $display("FAIL pre_edge got %h want 000", square_x); end
      @(posedge pclk); #1;
      checks++; if (square_x !== 9'h001) begin errors++; $display("FAIL vsync_update got %h want 001", square_x); end
      @(negedge pclk); vsync_in = 1'b0;
   endtask

   task automatic test_start_click();
      do_move(4'd5);
      @(negedge pclk); start = 1'b1; click = 1'b1; click_cell = 4'd0;
      @(negedge pclk); start = 1'b0; click = 1'b0;
      @(negedge pclk);
      checks++; if ({start_en, player, winner} !== 4'b1000) begin errors++; $display("FAIL start_click_state got %b want 1000", {start_en, player, winner}); end
      do_vsync();
      checks++; if (square_x !== 9'h0 || square_o !== 9'h0) begin errors++; $display("FAIL start_click_squares got %h/%h want 0/0", square_x, square_o); end
      do_move(4'd0);
      do_vsync();
      checks++; if (player !== 1'b1 || square_x !== 9'h001) begin errors++; $display("FAIL post_start_move got %b/%h want 1/001", player, square_x); end
      @(posedge pclk); #2 rst = 1'b0;
      #1;
      checks++; if ({start_en, player, game_over, winner, square_x, square_o} !== 23'h0) begin errors++; $display("FAIL async_reset got %b%b%b %b %h %h want all 0", start_en, player, game_over, winner, square_x, square_o); end
      @(negedge pclk); rst = 1'b1;
      @(negedge pclk); @(negedge pclk);
      checks++; if (start_en !== 1'b0 || square_x !== 9'h0) begin errors++; $display("FAIL post_reset_idle got %b/%h want 0/000", start_en, square_x); end
   endtask

   initial begin
      test_reset();
      test_x_win();
      test_draw();
      test_reject();
      test_frame_sync();
      test_start_click();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
